// File: rtl/game_pkg.sv
// Shared constants, cell codes, scan directions and FSM states for the 5x5 game board.
package game_pkg;

    localparam int BOARD_DIM = 5;
    localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [1:0] {
        DIR_RIGHT,
        DIR_DOWN,
        DIR_DOWN_RIGHT,
        DIR_DOWN_LEFT
    } dir_e;

    typedef enum logic [1:0] {
        PLAY,
        SCAN,
        DONE
    } state_e;

    function automatic int cell_index(input int r, input int c);
        return r * BOARD_DIM + c;
    endfunction

    function automatic int dir_drow(input dir_e d);
        return (d == DIR_RIGHT) ? 0 : 1;
    endfunction

    function automatic int dir_dcol(input dir_e d);
        case (d)
            DIR_RIGHT:      return 1;
            DIR_DOWN:       return 0;
            DIR_DOWN_RIGHT: return 1;
            default:        return -1;
        endcase
    endfunction

endpackage

// File: rtl/game_sequencer_line_match.sv
// Combinational check: does a WIN_LEN line of the given code start at (row,col)
// in any of the four scan directions? Lines leaving the board never match.
module line_match #(
    parameter int BOARD_DIM = game_pkg::BOARD_DIM,
    parameter int WIN_LEN   = 4
) (
    input  logic [2*BOARD_DIM*BOARD_DIM-1:0] i_board,
    input  logic [2:0]                       i_row,
    input  logic [2:0]                       i_col,
    input  logic [1:0]                       i_code,
    output logic                             o_hit
);
    import game_pkg::*;

    int   w_r;
    int   w_c;
    logic w_line_ok;

    always_comb begin
        o_hit     = 1'b0;
        w_r       = 0;
        w_c       = 0;
        w_line_ok = 1'b0;
        for (int d = 0; d < 4; d++) begin
            w_line_ok = 1'b1;
            for (int k = 0; k < WIN_LEN; k++) begin
                w_r = int'(i_row) + dir_drow(dir_e'(2'(d))) * k;
                w_c = int'(i_col) + dir_dcol(dir_e'(2'(d))) * k;
                if (w_r >= BOARD_DIM || w_c < 0 || w_c >= BOARD_DIM) begin
                    w_line_ok = 1'b0;
                end else if (i_board[2*cell_index(w_r, w_c) +: 2] != i_code) begin
                    w_line_ok = 1'b0;
                end
            end
            if (w_line_ok) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game controller: board storage, cursor, turn order and a one-cell-per-cycle
// win scan after each placement; reports win/draw to the match manager.
module game_sequencer #(
    parameter int BOARD_DIM = game_pkg::BOARD_DIM,
    parameter int WIN_LEN   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             btn_l,
    input  logic                             btn_r,
    input  logic                             btn_u,
    input  logic                             btn_d,
    input  logic                             place,
    input  logic                             new_game,
    output logic [2*BOARD_DIM*BOARD_DIM-1:0] board,
    output logic [2:0]                       cursor_row,
    output logic [2:0]                       cursor_col,
    output logic                             player1_turn,
    output logic                             player2_turn,
    output logic                             busy,
    output logic                             game_finished,
    output logic                             last_winner,
    output logic                             draw,
    output game_pkg::state_e                 dbg_state
);
    import game_pkg::*;

    localparam int         BW        = 2 * BOARD_DIM * BOARD_DIM;
    localparam logic [2:0] POS_MAX   = 3'(BOARD_DIM - 1);
    localparam logic [2:0] POS_MID   = 3'(BOARD_DIM / 2);
    localparam logic [4:0] LAST_CELL = 5'(BOARD_DIM * BOARD_DIM - 1);
    localparam logic [4:0] FULL_CNT  = 5'(BOARD_DIM * BOARD_DIM);

    state_e      r_state,      w_state_nxt;
    logic [BW-1:0] r_board,    w_board_nxt;
    logic [2:0]  r_cur_row,    w_cur_row_nxt;
    logic [2:0]  r_cur_col,    w_cur_col_nxt;
    logic        r_mover,      w_mover_nxt;
    logic        r_starter,    w_starter_nxt;
    logic [4:0]  r_move_cnt,   w_move_cnt_nxt;
    logic [4:0]  r_scan_idx,   w_scan_idx_nxt;
    logic [2:0]  r_scan_row,   w_scan_row_nxt;
    logic [2:0]  r_scan_col,   w_scan_col_nxt;
    logic        r_finished,   w_finished_nxt;
    logic        r_last_winner, w_last_winner_nxt;
    logic        r_draw,       w_draw_nxt;

    logic [1:0]  w_mover_code;
    logic [1:0]  w_cur_cell;
    int          w_cur_idx;
    logic        w_hit;

    assign w_mover_code = r_mover ? CELL_P2 : CELL_P1;
    assign w_cur_idx    = cell_index(int'(r_cur_row), int'(r_cur_col));
    assign w_cur_cell   = r_board[2*w_cur_idx +: 2];

    // Scan position is kept as row/col alongside the linear index to avoid a divider.
    line_match #(
        .BOARD_DIM (BOARD_DIM),
        .WIN_LEN   (WIN_LEN)
    ) u_line_match (
        .i_board (r_board),
        .i_row   (r_scan_row),
        .i_col   (r_scan_col),
        .i_code  (w_mover_code),
        .o_hit   (w_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= PLAY;
            r_board       <= '0;
            r_cur_row     <= POS_MID;
            r_cur_col     <= POS_MID;
            r_mover       <= 1'b0;
            r_starter     <= 1'b0;
            r_move_cnt    <= '0;
            r_scan_idx    <= '0;
            r_scan_row    <= '0;
            r_scan_col    <= '0;
            r_finished    <= 1'b0;
            r_last_winner <= 1'b0;
            r_draw        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_board       <= w_board_nxt;
            r_cur_row     <= w_cur_row_nxt;
            r_cur_col     <= w_cur_col_nxt;
            r_mover       <= w_mover_nxt;
            r_starter     <= w_starter_nxt;
            r_move_cnt    <= w_move_cnt_nxt;
            r_scan_idx    <= w_scan_idx_nxt;
            r_scan_row    <= w_scan_row_nxt;
            r_scan_col    <= w_scan_col_nxt;
            r_finished    <= w_finished_nxt;
            r_last_winner <= w_last_winner_nxt;
            r_draw        <= w_draw_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_board_nxt       = r_board;
        w_cur_row_nxt     = r_cur_row;
        w_cur_col_nxt     = r_cur_col;
        w_mover_nxt       = r_mover;
        w_starter_nxt     = r_starter;
        w_move_cnt_nxt    = r_move_cnt;
        w_scan_idx_nxt    = r_scan_idx;
        w_scan_row_nxt    = r_scan_row;
        w_scan_col_nxt    = r_scan_col;
        w_finished_nxt    = 1'b0;
        w_last_winner_nxt = r_last_winner;
        w_draw_nxt        = r_draw;

        if (new_game) begin
            // Overrides everything, including a scan that would finish this cycle.
            w_state_nxt    = PLAY;
            w_board_nxt    = '0;
            w_cur_row_nxt  = POS_MID;
            w_cur_col_nxt  = POS_MID;
            w_move_cnt_nxt = '0;
            w_scan_idx_nxt = '0;
            w_scan_row_nxt = '0;
            w_scan_col_nxt = '0;
            w_draw_nxt     = 1'b0;
            w_starter_nxt  = ~r_starter;
            w_mover_nxt    = ~r_starter;
        end else begin
            case (r_state)
                PLAY: begin
                    if (place) begin
                        if (w_cur_cell == CELL_EMPTY) begin
                            w_board_nxt[2*w_cur_idx +: 2] = w_mover_code;
                            w_move_cnt_nxt = r_move_cnt + 5'd1;
                            w_scan_idx_nxt = '0;
                            w_scan_row_nxt = '0;
                            w_scan_col_nxt = '0;
                            w_state_nxt    = SCAN;
                        end
                    end else if (btn_l) begin
                        w_cur_col_nxt = (r_cur_col == 3'd0) ? POS_MAX : r_cur_col - 3'd1;
                    end else if (btn_r) begin
                        w_cur_col_nxt = (r_cur_col == POS_MAX) ? 3'd0 : r_cur_col + 3'd1;
                    end else if (btn_u) begin
                        w_cur_row_nxt = (r_cur_row == 3'd0) ? POS_MAX : r_cur_row - 3'd1;
                    end else if (btn_d) begin
                        w_cur_row_nxt = (r_cur_row == POS_MAX) ? 3'd0 : r_cur_row + 3'd1;
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        w_state_nxt       = DONE;
                        w_finished_nxt    = 1'b1;
                        w_last_winner_nxt = r_mover;
                    end else if (r_scan_idx == LAST_CELL) begin
                        if (r_move_cnt == FULL_CNT) begin
                            w_state_nxt    = DONE;
                            w_finished_nxt = 1'b1;
                            w_draw_nxt     = 1'b1;
                        end else begin
                            w_mover_nxt = ~r_mover;
                            w_state_nxt = PLAY;
                        end
                    end else begin
                        w_scan_idx_nxt = r_scan_idx + 5'd1;
                        if (r_scan_col == POS_MAX) begin
                            w_scan_col_nxt = 3'd0;
                            w_scan_row_nxt = r_scan_row + 3'd1;
                        end else begin
                            w_scan_col_nxt = r_scan_col + 3'd1;
                        end
                    end
                end
                DONE: begin
                end
                default: begin
                    w_state_nxt = PLAY;
                end
            endcase
        end
    end

    assign board         = r_board;
    assign cursor_row    = r_cur_row;
    assign cursor_col    = r_cur_col;
    assign player1_turn  = (r_state != DONE) && !r_mover;
    assign player2_turn  = (r_state != DONE) && r_mover;
    assign busy          = (r_state == SCAN);
    assign game_finished = r_finished;
    assign last_winner   = r_last_winner;
    assign draw          = r_draw;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: cursor vector table plus hand-written game sequences.
module tb_game_sequencer;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_l, btn_r, btn_u, btn_d, place, new_game;
    logic [49:0] board;
    logic [2:0]  cursor_row, cursor_col;
    logic        player1_turn, player2_turn, busy, game_finished, last_winner, draw;
    state_e      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int fin_cnt = 0;

    typedef struct {
        logic       l, r, u, d;
        logic [2:0] row, col;
    } cur_vec_t;

    cur_vec_t vecs[12];

    always #5 clk = ~clk;

    game_sequencer #(.BOARD_DIM(5), .WIN_LEN(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_l         (btn_l),
        .btn_r         (btn_r),
        .btn_u         (btn_u),
        .btn_d         (btn_d),
        .place         (place),
        .new_game      (new_game),
        .board         (board),
        .cursor_row    (cursor_row),
        .cursor_col    (cursor_col),
        .player1_turn  (player1_turn),
        .player2_turn  (player2_turn),
        .busy          (busy),
        .game_finished (game_finished),
        .last_winner   (last_winner),
        .draw          (draw),
        .dbg_state     (dbg_state)
    );

    // game_finished spans posedge to posedge, so each pulse is seen at exactly one negedge.
    always @(negedge clk) begin
        if (game_finished === 1'b1) fin_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic l, input logic r, input logic u, input logic d,
                         input logic p, input logic ng);
        btn_l = l; btn_r = r; btn_u = u; btn_d = d; place = p; new_game = ng;
        @(posedge clk);
        #1;
        btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0; place = 0; new_game = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0; place = 0; new_game = 0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic goto(input int r, input int c);
        int n;
        n = 0;
        while (cursor_col != 3'(c) && n < 6) begin
            pulse(0, 1, 0, 0, 0, 0);
            n++;
        end
        n = 0;
        while (cursor_row != 3'(r) && n < 6) begin
            pulse(0, 0, 0, 1, 0, 0);
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            step(1);
            n++;
        end
    endtask

    // Non-winning placement: busy must last exactly 25 cycles.
    task automatic place_at(input int r, input int c);
        int n;
        goto(r, c);
        pulse(0, 0, 0, 0, 1, 0);
        wait_idle(n);
        check($sformatf("scan_len(%0d,%0d)", r, c), 64'(n), 64'd25);
    endtask

    function automatic logic [1:0] cell_of(input int r, input int c);
        logic [49:0] b;
        b = board;
        return b[2*(r*5+c) +: 2];
    endfunction

    function automatic logic [1:0] draw_code(input int r, input int c);
        logic mid;
        mid = (c == 2) || (c == 3);
        if (r % 2 == 0) return mid ? CELL_P2 : CELL_P1;
        return mid ? CELL_P1 : CELL_P2;
    endfunction

    initial begin
        int          n;
        int          fin_base;
        logic [49:0] saved;
        logic [49:0] exp_board;
        int          p1_cells[$];
        int          p2_cells[$];
        int          idx;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd4};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd4};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 3'd4};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd3};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 3'd4};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 3'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 3'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 3'd1};

        // Reset state
        do_reset();
        check("rst_board", 64'(board), 64'd0);
        check("rst_cursor", 64'({cursor_row, cursor_col}), 64'({3'd2, 3'd2}));
        check("rst_leds", 64'({player1_turn, player2_turn}), 64'b10);
        check("rst_flags", 64'({busy, game_finished, last_winner, draw}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(PLAY));

        // Cursor wrap and move priority
        for (int i = 0; i < 12; i++) begin
            pulse(vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d, 1'b0, 1'b0);
            check($sformatf("vec%0d_row", i), 64'(cursor_row), 64'(vecs[i].row));
            check($sformatf("vec%0d_col", i), 64'(cursor_col), 64'(vecs[i].col));
        end

        // Place at (2,2), then on the occupied cell
        do_reset();
        pulse(0, 0, 0, 0, 1, 0);
        check("place_cell12", 64'(cell_of(2, 2)), 64'(CELL_P1));
        check("place_busy", 64'(busy), 64'd1);
        wait_idle(n);
        check("busy_cycles", 64'(n), 64'd25);
        check("turn_after_scan", 64'({player1_turn, player2_turn}), 64'b01);
        saved = board;
        pulse(0, 0, 0, 0, 1, 0);
        check("occupied_board", 64'(board), 64'(saved));
        check("occupied_busy", 64'(busy), 64'd0);
        check("occupied_turn", 64'(player2_turn), 64'd1);

        // Horizontal P1 win on row 0
        do_reset();
        fin_base = fin_cnt;
        place_at(0, 0); place_at(4, 0);
        place_at(0, 1); place_at(4, 1);
        place_at(0, 2); place_at(4, 4);
        goto(0, 3);
        pulse(0, 0, 0, 0, 1, 0);
        check("hwin_t1_busy", 64'(busy), 64'd1);
        check("hwin_t1_fin", 64'(game_finished), 64'd0);
        step(1);
        check("hwin_t2_fin", 64'(game_finished), 64'd1);
        check("hwin_winner", 64'(last_winner), 64'd0);
        check("hwin_leds", 64'({player1_turn, player2_turn}), 64'b00);
        check("hwin_draw", 64'(draw), 64'd0);
        step(1);
        check("hwin_t3_fin", 64'(game_finished), 64'd0);
        check("hwin_cell", 64'(cell_of(0, 3)), 64'(CELL_P1));
        saved = board;
        pulse(1, 0, 0, 0, 0, 0);
        check("done_cursor_frozen", 64'(cursor_col), 64'd3);
        goto(1, 3);
        pulse(0, 0, 0, 0, 1, 0);
        check("done_board_frozen", 64'(board), 64'(saved));
        check("hwin_pulses", 64'(fin_cnt - fin_base), 64'd1);

        // new_game: starter toggles to P2, last_winner held
        pulse(0, 0, 0, 0, 0, 1);
        check("ng_board", 64'(board), 64'd0);
        check("ng_cursor", 64'({cursor_row, cursor_col}), 64'({3'd2, 3'd2}));
        check("ng_leds", 64'({player1_turn, player2_turn}), 64'b01);
        check("ng_flags", 64'({busy, draw, last_winner}), 64'd0);

        // Anti-diagonal P2 win starting at (0,4): hit at scan idx 4
        fin_base = fin_cnt;
        place_at(0, 4); place_at(0, 0);
        place_at(1, 3); place_at(1, 0);
        place_at(2, 2); place_at(3, 3);
        goto(3, 1);
        pulse(0, 0, 0, 0, 1, 0);
        n = 0;
        while (!game_finished && n < 40) begin
            step(1);
            n++;
        end
        check("adiag_latency", 64'(n), 64'd5);
        check("adiag_winner", 64'(last_winner), 64'd1);
        step(3);
        check("adiag_pulses", 64'(fin_cnt - fin_base), 64'd1);

        // Draw: 25 moves on a board with no 4-in-line, P1 starts
        pulse(0, 0, 0, 0, 0, 1);
        check("draw_start_turn", 64'({player1_turn, player2_turn}), 64'b10);
        exp_board = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                exp_board[2*(r*5+c) +: 2] = draw_code(r, c);
                if (draw_code(r, c) == CELL_P1) p1_cells.push_back(r*5+c);
                else p2_cells.push_back(r*5+c);
            end
        end
        fin_base = fin_cnt;
        for (int i = 0; i < 25; i++) begin
            idx = (i % 2 == 0) ? p1_cells[i/2] : p2_cells[i/2];
            place_at(idx / 5, idx % 5);
        end
        check("draw_fin", 64'(game_finished), 64'd1);
        check("draw_flag", 64'(draw), 64'd1);
        check("draw_winner_held", 64'(last_winner), 64'd1);
        check("draw_leds", 64'({player1_turn, player2_turn}), 64'b00);
        check("draw_board", 64'(board), 64'(exp_board));
        step(2);
        check("draw_pulses", 64'(fin_cnt - fin_base), 64'd1);

        // new_game in the cycle a winning scan would finish
        pulse(0, 0, 0, 0, 0, 1);
        check("ng2_draw_clr", 64'(draw), 64'd0);
        check("ng2_turn", 64'({player1_turn, player2_turn}), 64'b01);
        place_at(0, 0); place_at(4, 0);
        place_at(0, 1); place_at(4, 1);
        place_at(0, 2); place_at(4, 4);
        fin_base = fin_cnt;
        goto(0, 3);
        pulse(0, 0, 0, 0, 1, 0);
        pulse(0, 0, 0, 0, 0, 1);
        check("ngwin_board", 64'(board), 64'd0);
        check("ngwin_busy", 64'(busy), 64'd0);
        check("ngwin_turn", 64'({player1_turn, player2_turn}), 64'b10);
        step(5);
        check("ngwin_pulses", 64'(fin_cnt - fin_base), 64'd0);
        check("ngwin_winner_held", 64'(last_winner), 64'd1);

        // new_game mid-SCAN
        fin_base = fin_cnt;
        goto(2, 2);
        pulse(0, 0, 0, 0, 1, 0);
        step(10);
        check("ngscan_busy_before", 64'(busy), 64'd1);
        pulse(0, 0, 0, 0, 0, 1);
        check("ngscan_board", 64'(board), 64'd0);
        check("ngscan_cursor", 64'({cursor_row, cursor_col}), 64'({3'd2, 3'd2}));
        check("ngscan_busy", 64'(busy), 64'd0);
        check("ngscan_turn", 64'({player1_turn, player2_turn}), 64'b01);
        step(30);
        check("ngscan_pulses", 64'(fin_cnt - fin_base), 64'd0);

        // Asynchronous reset mid-SCAN
        fin_base = fin_cnt;
        pulse(0, 0, 0, 0, 1, 0);
        step(5);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("arst_busy_low", 64'(busy), 64'd0);
        rst_n = 1'b1;
        check("arst_board", 64'(board), 64'd0);
        check("arst_turn", 64'({player1_turn, player2_turn}), 64'b10);
        check("arst_winner", 64'(last_winner), 64'd0);
        step(30);
        check("arst_pulses", 64'(fin_cnt - fin_base), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Controls the 5x5 game board: owns board storage, cursor position, turn order and the end-of-game decision.
- Accepts debounced single-cycle button pulses and applies moves.
- After each placement, runs a fixed-latency sequential win scan.
- Reports the result to the match manager (game_finished, last_winner). Its board and cursor outputs drive the VGA display.

Parameters:
- BOARD_DIM, 5, board side length (cursor and scan logic sized for 5).
- WIN_LEN, 4, consecutive same-player marks that win (2..BOARD_DIM).

Ports:
- clk  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- btn_l  in  1  one-cycle pulse: cursor left
- btn_r  in  1  one-cycle pulse: cursor right
- btn_u  in  1  one-cycle pulse: cursor up
- btn_d  in  1  one-cycle pulse: cursor down
- place  in  1  one-cycle pulse: place marker at cursor
- new_game  in  1  one-cycle pulse: clear board, start next game
- board  out  50  flat board; cell (r,c) at bits [2*(r*5+c)+:2]; 00 empty, 01 P1, 10 P2
- cursor_row  out  3  0..4
- cursor_col  out  3  0..4
- player1_turn  out  1  LED
- player2_turn  out  1  LED
- busy  out  1  high in SCAN
- game_finished  out  1  one-cycle pulse on win or draw
- last_winner  out  1  0 = P1, 1 = P2; valid from the game_finished pulse
- draw  out  1  high in DONE if the game ended full with no winner

Behaviour:
- Reset values:
  - board all 00; cursor (2,2); mover = P1; starter = P1; move_cnt = 0.
  - State PLAY; player1_turn = 1, player2_turn = 0.
  - busy, game_finished, last_winner and draw all 0.
- States: PLAY, SCAN, DONE.
- new_game (any state, highest priority):
  - Next cycle: board cleared, cursor (2,2), move_cnt = 0, draw = 0, state PLAY.
  - starter toggles, and mover = new starter.
  - last_winner is held.
- PLAY, per cycle:
  - If place is high and the cursor cell is 00: write the mover code, move_cnt += 1, scan_idx = 0, go to SCAN.
  - place on an occupied cell is ignored; no state change.
  - Otherwise apply at most one move, priority L > R > U > D.
  - Cursor moves wrap around: 0 - 1 = 4 and 4 + 1 = 0.
  - place has priority over moves in the same cycle; the move is dropped.
- SCAN, one cell per cycle, scan_idx 0..24 (row-major):
  - A cell wins if the WIN_LEN cells starting at it in any of four directions all equal the mover code.
  - Directions: right, down, down-right, down-left.
  - Lines that run off the board do not match.
  - On a hit: go to DONE, pulse game_finished, last_winner = mover.
  - At scan_idx = 24 with no hit and move_cnt = 25: go to DONE, pulse game_finished, draw = 1, last_winner unchanged.
  - At scan_idx = 24 with no hit and move_cnt < 25: mover toggles, go to PLAY.
  - All button inputs are ignored in SCAN.
- DONE:
  - Both turn LEDs 0.
  - Board and cursor frozen; everything except new_game is ignored.
- Turn LEDs: in PLAY and SCAN, they show the mover one-hot.
- Latency: place sampled at edge T, cell visible at T+1, scan_idx k evaluated in cycle T+1+k.
  - A win found at idx k asserts game_finished in cycle T+2+k.
  - A no-win scan returns to PLAY with the toggled mover at T+26.
- game_finished is registered and high for exactly 1 cycle per game.
- Async reset mid-SCAN discards the scan; no game_finished is emitted.
- new_game in the cycle a scan would finish: new_game wins; no game_finished pulse.

Decomposition:
- Package game_pkg:
  - BOARD_DIM, cell codes (CELL_EMPTY, CELL_P1, CELL_P2).
  - Direction encoding and the state enum {PLAY, SCAN, DONE}.
  - cell_index(r,c) function.
- Sub-module line_match: combinational; inputs board, start row/col, mover code; output hit over the four directions for WIN_LEN.
- The FSM, cursor, counters and board register stay in game_sequencer.

Test Plan:
- Cursor wrap and move priority:
  - From reset, btn_l x3 -> cursor_col 4.
  - Then btn_u x3 -> cursor_row 4.
  - btn_l and btn_r in the same cycle -> only left applied.
- Place and occupied cell:
  - place at (2,2) -> board cell 12 = 01, busy high 25 cycles, then player2_turn = 1.
  - place again at (2,2) -> board unchanged, no SCAN.
- Horizontal win (WIN_LEN = 4):
  - P1 fills (0,0)..(0,3), P2 plays elsewhere.
  - Hit at scan idx 0 -> game_finished 1 cycle, 2 cycles after the place cycle.
  - last_winner = 0; both LEDs 0.
- Anti-diagonal win for P2: cells (0,4),(1,3),(2,2),(3,1) -> last_winner = 1, single game_finished pulse.
- Draw: 25-move sequence with no 4-line -> game_finished pulse, draw = 1, last_winner unchanged from the previous game.
- new_game during SCAN and reset mid-SCAN -> no game_finished pulse.
  - After new_game: board all 0, cursor (2,2), starter toggled (player2_turn = 1 after the first new_game).
